// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the renderer and the VGA connector.
interface vga_timing_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       frame_start;
   logic       line_start;

   modport master (output DrawX, DrawY, blank, hs, vs, frame_start, line_start);
   modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, line_start);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, display enable, frame/line pulses,
// and hs/vs delayed to line up with the renderer's registered colour output.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit SYNC_POL   = 1'b0,
   parameter int SYNC_DELAY = 1
) (
   input  logic          vga_clk,
   input  logic          reset_n,
   vga_timing_if.master  vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // Thresholds held in 11 bits so an end-of-range equal to 1024 still compares correctly.
   localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
   end
   if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be 0..4");
   end

   logic [9:0] x_q, y_q, x_nx, y_nx;
   logic       blank_q, fs_q, ls_q;
   logic       hsync_nx, vsync_nx;
   // Stage 0 is aligned with DrawX; hs/vs tap stage SYNC_DELAY. Bit 1 = hsync, bit 0 = vsync.
   logic [SYNC_DELAY:0][1:0] sync_pipe;

   always_comb begin
      x_nx = (x_q == H_MAX) ? 10'd0 : x_q + 10'd1;
      y_nx = y_q;
      if (x_q == H_MAX)
         y_nx = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
      hsync_nx = ({1'b0, x_nx} >= HS_START && {1'b0, x_nx} < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_nx = ({1'b0, y_nx} >= VS_START && {1'b0, y_nx} < VS_END) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q       <= H_MAX;
         y_q       <= V_MAX;
         blank_q   <= 1'b0;
         fs_q      <= 1'b0;
         ls_q      <= 1'b0;
         sync_pipe <= {(2*(SYNC_DELAY+1)){~SYNC_POL}};
      end else begin
         x_q          <= x_nx;
         y_q          <= y_nx;
         blank_q      <= ({1'b0, x_nx} < H_VIS) && ({1'b0, y_nx} < V_VIS);
         fs_q         <= (x_nx == 10'd0) && (y_nx == 10'd0);
         ls_q         <= (x_nx == 10'd0);
         sync_pipe[0] <= {hsync_nx, vsync_nx};
         for (int i = 1; i <= SYNC_DELAY; i++)
            sync_pipe[i] <= sync_pipe[i-1];
      end
   end

   assign vga.DrawX       = x_q;
   assign vga.DrawY       = y_q;
   assign vga.blank       = blank_q;
   assign vga.frame_start = fs_q;
   assign vga.line_start  = ls_q;
   assign vga.hs          = sync_pipe[SYNC_DELAY][1];
   assign vga.vs          = sync_pipe[SYNC_DELAY][0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing and async reset,
// plus a tiny 16x11 raster instance (SYNC_DELAY=2) for whole-frame counts.
module tb_vga_timing_gen;
   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   vga_timing_if d ();
   vga_timing_if s ();

   vga_timing_gen u_dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vga     (d)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b0), .SYNC_DELAY(2)
   ) u_small (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vga     (s)
   );

   always #20 vga_clk = ~vga_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge vga_clk);
         @(negedge vga_clk);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_x"},  d.DrawX, 799);
      chk({tag, "_y"},  d.DrawY, 524);
      chk({tag, "_bl"}, d.blank, 0);
      chk({tag, "_hs"}, d.hs, 1);
      chk({tag, "_vs"}, d.vs, 1);
      chk({tag, "_fs"}, d.frame_start, 0);
      chk({tag, "_ls"}, d.line_start, 0);
   endtask

   initial begin
      int cnt;
      int fs_n, ls_n, bl_n, vs_n, hs_n, hs_first;

      // Reset held, before and after clock edges
      @(negedge vga_clk);
      chk_reset("rst0");
      tick(2);
      chk_reset("rst1");
      chk("s_rst_x", s.DrawX, 15);
      chk("s_rst_y", s.DrawY, 10);
      chk("s_rst_hs", s.hs, 1);

      // Release: first edge lands on (0,0)
      reset_n = 1'b1;
      tick(1);
      chk("first_x", d.DrawX, 0);
      chk("first_y", d.DrawY, 0);
      chk("first_bl", d.blank, 1);
      chk("first_fs", d.frame_start, 1);
      chk("first_ls", d.line_start, 1);
      tick(1);
      chk("second_x", d.DrawX, 1);
      chk("second_fs", d.frame_start, 0);
      chk("second_ls", d.line_start, 0);

      // Visible edge
      tick(638);
      chk("x639", d.DrawX, 639);
      chk("bl639", d.blank, 1);
      tick(1);
      chk("bl640", d.blank, 0);

      // hsync, delayed one cycle
      tick(16);
      chk("x656", d.DrawX, 656);
      chk("hs656", d.hs, 1);
      tick(1);
      chk("hs657", d.hs, 0);
      cnt = 0;
      while (d.hs == 1'b0 && cnt < 200) begin
         cnt++;
         tick(1);
      end
      chk("hs_width", cnt, 96);
      chk("hs_end_x", d.DrawX, 753);
      chk("vs_line0", d.vs, 1);

      // Line wrap
      tick(46);
      chk("x799", d.DrawX, 799);
      chk("y0", d.DrawY, 0);
      tick(1);
      chk("wrap_x", d.DrawX, 0);
      chk("wrap_y", d.DrawY, 1);
      chk("wrap_ls", d.line_start, 1);
      chk("wrap_fs", d.frame_start, 0);
      chk("wrap_bl", d.blank, 1);

      // Asynchronous reset with hs low in the pipe
      tick(700);
      chk("mid_x", d.DrawX, 700);
      chk("mid_hs", d.hs, 0);
      #5 reset_n = 1'b0;
      #1 chk_reset("async");
      @(negedge vga_clk);
      chk_reset("async_hold");
      reset_n = 1'b1;
      tick(1);
      chk("restart_x", d.DrawX, 0);
      chk("restart_y", d.DrawY, 0);
      chk("restart_fs", d.frame_start, 1);
      chk("restart_hs", d.hs, 1);

      // Whole frame on the small instance: 16x11 = 176 cycles
      fs_n = 0; ls_n = 0; bl_n = 0; vs_n = 0; hs_n = 0; hs_first = -1;
      for (int c = 0; c < 176; c++) begin
         if (c > 0) tick(1);
         fs_n += int'(s.frame_start);
         ls_n += int'(s.line_start);
         bl_n += int'(s.blank);
         vs_n += int'(!s.vs);
         hs_n += int'(!s.hs);
         if (hs_first < 0 && s.hs == 1'b0) hs_first = c;
         if (c == 95) begin
            chk("s_x15", s.DrawX, 15);
            chk("s_y5", s.DrawY, 5);
         end
         if (c == 96) begin
            chk("s_wrap_x", s.DrawX, 0);
            chk("s_wrap_y", s.DrawY, 6);
            chk("s_wrap_bl", s.blank, 0);
            chk("s_wrap_ls", s.line_start, 1);
            chk("s_wrap_fs", s.frame_start, 0);
         end
         if (c == 175) begin
            chk("s_last_x", s.DrawX, 15);
            chk("s_last_y", s.DrawY, 10);
         end
      end
      chk("s_fs_count", fs_n, 1);
      chk("s_ls_count", ls_n, 11);
      chk("s_blank_count", bl_n, 48);
      chk("s_vs_low", vs_n, 32);
      chk("s_hs_low", hs_n, 33);
      chk("s_hs_first", hs_first, 12);
      tick(1);
      chk("s_frame_x", s.DrawX, 0);
      chk("s_frame_y", s.DrawY, 0);
      chk("s_frame_fs", s.frame_start, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
